// File: rtl/ddr_traffic_gen_chk.sv
// DDR3 traffic generator with in-order read-back checker: sweeps rank/bank/row/col,
// issues write/read commands and scores returned read data. Optional DDR_TGC_ERR_LOG_EN adds a first-error log.
module ddr_traffic_gen_chk #(
    parameter int DATA_W   = 128,
    parameter int ROW_NUM  = 1024,
    parameter int COL_NUM  = 16,
    parameter int COL_STEP = 8,
    parameter int BANK_NUM = 1,
    parameter int RANK_NUM = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              power_on_rst,
    input  logic              start,
    input  logic              mode,
    input  logic [31:0]       seed,
    input  logic [7:0]        ba_cmd_pm,
    output logic [33:0]       command,
    output logic              valid,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_data_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [31:0]       rd_cnt
`ifdef DDR_TGC_ERR_LOG_EN
    ,
    output logic [23:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic              err_seen
`endif
);
    localparam int NWORDS = DATA_W / 32;
    localparam int NADDR  = RANK_NUM * BANK_NUM * ROW_NUM * (COL_NUM / COL_STEP);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [9:0]      COL_INC   = 10'(COL_STEP);
    localparam logic [9:0]      COL_LAST  = 10'(COL_NUM - COL_STEP);
    localparam logic [12:0]     ROW_LAST  = 13'(ROW_NUM - 1);
    localparam logic [2:0]      BANK_LAST = 3'(BANK_NUM - 1);
    localparam logic [1:0]      RANK_LAST = 2'(RANK_NUM - 1);
    localparam logic [31:0]     LAST_IDX  = 32'(NADDR - 1);
    localparam logic [31:0]     NREAD     = 32'(NADDR);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic              mode_r;
    logic [31:0]       seed_r;
    logic [1:0]        rank_c, nxt_rank;
    logic [2:0]        bank_c, nxt_bank;
    logic [12:0]       row_c, nxt_row;
    logic [9:0]        col_c, nxt_col;
    logic [31:0]       idx_c;
    logic              rw_c;
    logic [TO_W-1:0]   idle_cnt;
    logic              timed_out;
    logic              accept, last_addr, last_cmd, restart, rd_window, beat_bad;
    logic [DATA_W-1:0] exp_data;

    // word k of data(idx) = seed ^ {k[7:0], idx[23:0]}
    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] s, input logic [23:0] i);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int k = 0; k < NWORDS; k++)
            p[k*32 +: 32] = s ^ {8'(k), i};
        return p;
    endfunction

    // Field-wise address increment: col inner, then row, bank, rank; every field wraps
    always_comb begin
        nxt_col  = col_c + COL_INC;
        nxt_row  = row_c;
        nxt_bank = bank_c;
        nxt_rank = rank_c;
        if (col_c == COL_LAST) begin
            nxt_col = '0;
            if (row_c == ROW_LAST) begin
                nxt_row = '0;
                if (bank_c == BANK_LAST) begin
                    nxt_bank = '0;
                    nxt_rank = (rank_c == RANK_LAST) ? 2'd0 : rank_c + 2'd1;
                end else begin
                    nxt_bank = bank_c + 3'd1;
                end
            end else begin
                nxt_row = row_c + 13'd1;
            end
        end
    end

    assign accept    = (state == S_ISSUE) && ba_cmd_pm[bank_c];
    assign last_addr = (idx_c == LAST_IDX);
    assign last_cmd  = rw_c && last_addr;
    assign restart   = start && (state == S_IDLE || state == S_DONE);
    assign rd_window = (state != S_IDLE) && read_data_valid;
    assign exp_data  = pattern(seed_r, rd_cnt[23:0]);
    assign beat_bad  = (rd_cnt >= NREAD) || (read_data != exp_data);

    assign busy = (state == S_ISSUE) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign pass = done && !timed_out && (err_cnt == 16'd0) && (rd_cnt == NREAD);

    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            state      <= S_IDLE;
            mode_r     <= 1'b0;
            seed_r     <= '0;
            rank_c     <= '0;
            bank_c     <= '0;
            row_c      <= '0;
            col_c      <= '0;
            idx_c      <= '0;
            rw_c       <= 1'b0;
            idle_cnt   <= '0;
            timed_out  <= 1'b0;
            command    <= '0;
            valid      <= 1'b0;
            write_data <= '0;
            err_cnt    <= '0;
            rd_cnt     <= '0;
`ifdef DDR_TGC_ERR_LOG_EN
            first_err_idx  <= '0;
            first_err_data <= '0;
            err_seen       <= 1'b0;
`endif
        end else begin
            command    <= '0;
            valid      <= 1'b0;
            write_data <= '0;

            if (restart) begin
                state     <= S_ISSUE;
                mode_r    <= mode;
                seed_r    <= seed;
                rank_c    <= '0;
                bank_c    <= '0;
                row_c     <= '0;
                col_c     <= '0;
                idx_c     <= '0;
                rw_c      <= 1'b0;
                idle_cnt  <= '0;
                timed_out <= 1'b0;
                err_cnt   <= '0;
                rd_cnt    <= '0;
`ifdef DDR_TGC_ERR_LOG_EN
                first_err_idx  <= '0;
                first_err_data <= '0;
                err_seen       <= 1'b0;
`endif
            end else begin
                if (accept) begin
                    command    <= {rank_c, rw_c, 1'b0, row_c, 1'b0, 1'b1, 1'b0, 1'b0, col_c, bank_c};
                    valid      <= 1'b1;
                    write_data <= rw_c ? '0 : pattern(seed_r, idx_c[23:0]);
                    // sweep: step every command, flip to reads after the last write;
                    // interleave: toggle rw, step only after the read
                    if (!mode_r || rw_c) begin
                        rank_c <= nxt_rank;
                        bank_c <= nxt_bank;
                        row_c  <= nxt_row;
                        col_c  <= nxt_col;
                        idx_c  <= last_addr ? 32'd0 : idx_c + 32'd1;
                    end
                    if (mode_r)
                        rw_c <= ~rw_c;
                    else if (last_addr)
                        rw_c <= 1'b1;
                    if (last_cmd) begin
                        state    <= S_DRAIN;
                        idle_cnt <= '0;
                    end
                end

                if (state == S_DRAIN) begin
                    if (rd_cnt == NREAD) begin
                        state <= S_DONE;
                    end else if (read_data_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TO_LAST) begin
                        state     <= S_DONE;
                        timed_out <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                if (rd_window) begin
                    rd_cnt <= rd_cnt + 32'd1;
                    if (beat_bad) begin
                        if (err_cnt != 16'hFFFF)
                            err_cnt <= err_cnt + 16'd1;
`ifdef DDR_TGC_ERR_LOG_EN
                        if (!err_seen) begin
                            err_seen       <= 1'b1;
                            first_err_idx  <= rd_cnt[23:0];
                            first_err_data <= read_data;
                        end
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr_traffic_gen_chk.sv
// Directed bench for ddr_traffic_gen_chk: loopback memory responder plus a linear
// sequence of reset, sweep, interleave, corruption, timeout and restart scenarios.
module tb_ddr_traffic_gen_chk;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              power_on_rst;
    logic              start;
    logic              mode;
    logic [31:0]       seed;
    logic [7:0]        ba_cmd_pm;
    logic [33:0]       command;
    logic              valid;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              busy, done, pass;
    logic [15:0]       err_cnt;
    logic [31:0]       rd_cnt;
`ifdef DDR_TGC_ERR_LOG_EN
    logic [23:0]       first_err_idx;
    logic [DATA_W-1:0] first_err_data;
    logic              err_seen;
`endif

    ddr_traffic_gen_chk #(
        .DATA_W(DATA_W), .ROW_NUM(4), .COL_NUM(16), .COL_STEP(8),
        .BANK_NUM(1), .RANK_NUM(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .power_on_rst(power_on_rst), .start(start), .mode(mode), .seed(seed),
        .ba_cmd_pm(ba_cmd_pm), .command(command), .valid(valid), .write_data(write_data),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .rd_cnt(rd_cnt)
`ifdef DDR_TGC_ERR_LOG_EN
        , .first_err_idx(first_err_idx), .first_err_data(first_err_data), .err_seen(err_seen)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // responder / monitor state (written only by the responder process)
    logic [33:0]       cmd_log[$];
    logic [DATA_W-1:0] wd_log[$];
    logic [DATA_W-1:0] rq[$];
    logic [DATA_W-1:0] mem[logic [26:0]];
    int  cyc = 0, first_v = -1, last_v = -10, consec = 0, rw_bad = 0, beat_num = 0;
    int  clr_ack = 0, inj_ack = 0;
    logic exp_rw = 1'b0;

    // control (written only by the main sequence)
    int  clr_req = 0, inj_req = 0, corrupt_beat = -1, drop_beat = -1;
    bit  pm_toggle = 1'b0;

    initial begin
        read_data       = '0;
        read_data_valid = 1'b0;
        ba_cmd_pm       = 8'hFF;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_req != clr_ack) begin
                cmd_log.delete(); wd_log.delete(); rq.delete();
                first_v = -1; last_v = -10; consec = 0; rw_bad = 0; beat_num = 0;
                exp_rw = 1'b0; clr_ack = clr_req;
            end
            // read return path: one beat per cycle, one cycle behind the read command
            read_data_valid = 1'b0;
            if (power_on_rst) begin
                rq.delete();
            end else if (inj_req != inj_ack) begin
                read_data = '0; read_data_valid = 1'b1; inj_ack = inj_req;
            end else if (rq.size() > 0) begin
                logic [DATA_W-1:0] d;
                d = rq.pop_front();
                if (beat_num != drop_beat) begin
                    if (beat_num == corrupt_beat) d[0] = ~d[0];
                    read_data = d; read_data_valid = 1'b1;
                end
                beat_num++;
            end
            if (valid) begin
                cmd_log.push_back(command);
                wd_log.push_back(write_data);
                if (last_v == cyc - 1) consec++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (command[31] !== exp_rw) rw_bad++;
                exp_rw = ~exp_rw;
                if (!command[31]) mem[command[29:3]] = write_data;
                else rq.push_back(mem.exists(command[29:3]) ? mem[command[29:3]] : '0);
            end
            ba_cmd_pm = pm_toggle ? ~ba_cmd_pm : 8'hFF;
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic clear_logs();
        clr_req++;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        chk("done_reached", done, 1);
    endtask

    initial begin
        power_on_rst = 1'b1; start = 1'b0; mode = 1'b0; seed = 32'h0;
        repeat (3) @(negedge clk);
        power_on_rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_rd_cnt", rd_cnt, 0);

        // 1: reset in the middle of ISSUE
        pulse_start();
        repeat (2) @(negedge clk);
        chk("t1_busy_pre", busy, 1);
        chk("t1_valid_pre", valid, 1);
        power_on_rst = 1'b1;
        repeat (3) @(negedge clk);
        power_on_rst = 1'b0;
        @(negedge clk);
        chk("t1_valid", valid, 0);
        chk("t1_command", command, 0);
        chk("t1_busy", busy, 0);
        chk("t1_err_cnt", err_cnt, 0);

        // 2: sweep, seed 0, permit always high
        clear_logs();
        mode = 1'b0; seed = 32'h0;
        pulse_start();
        wait_done(200);
        chk("t2_pass", pass, 1);
        chk("t2_rd_cnt", rd_cnt, 8);
        chk("t2_err_cnt", err_cnt, 0);
        chk("t2_busy", busy, 0);
        chk("t2_ncmd", cmd_log.size(), 16);
        chk("t2_cmd0", cmd_log[0], 34'h0_0000_8000);
        chk("t2_cmd1", cmd_log[1], 34'h0_0000_8040);
        chk("t2_cmd2", cmd_log[2], 34'h0_0002_8000);
        chk("t2_cmd8_rd", cmd_log[8], 34'h0_8000_8000);
        chk("t2_wd1_w0", wd_log[1][31:0], 32'h0000_0001);
        chk("t2_wd1_w3", wd_log[1][127:96], 32'h0300_0001);
        chk("t2_wd8_rd", wd_log[8], 0);
        chk("t2_b2b", last_v - first_v, 15);

        // 3: interleave, permit toggling each cycle
        clear_logs();
        mode = 1'b1; seed = 32'hA5A5_0000; pm_toggle = 1'b1;
        pulse_start();
        wait_done(400);
        pm_toggle = 1'b0;
        chk("t3_pass", pass, 1);
        chk("t3_ncmd", cmd_log.size(), 16);
        chk("t3_rw_alt", rw_bad, 0);
        chk("t3_no_consec", consec, 0);
        chk("t3_cmd1_rd", cmd_log[1], 34'h0_8000_8000);
        chk("t3_wd0_w1", wd_log[0][63:32], 32'hA4A5_0000);

        // 4: corrupt bit 0 of the third read beat
        clear_logs();
        mode = 1'b0; seed = 32'h0; corrupt_beat = 2;
        pulse_start();
        wait_done(200);
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_pass", pass, 0);
        chk("t4_rd_cnt", rd_cnt, 8);
`ifdef DDR_TGC_ERR_LOG_EN
        chk("t4_err_seen", err_seen, 1);
        chk("t4_first_idx", first_err_idx, 2);
        chk("t4_first_data", first_err_data, 128'h03000002_02000002_01000002_00000003);
`endif
        corrupt_beat = -1;

        // 5: last read return dropped -> drain timeout
        clear_logs();
        drop_beat = 7;
        pulse_start();
        for (int i = 0; i < 200 && rd_cnt != 7; i++) @(negedge clk);
        chk("t5_rd7", rd_cnt, 7);
        repeat (TIMEOUT / 2) @(negedge clk);
        chk("t5_not_done_early", done, 0);
        wait_done(TIMEOUT + 20);
        chk("t5_pass", pass, 0);
        chk("t5_rd_cnt", rd_cnt, 7);
        chk("t5_err_cnt", err_cnt, 0);
        drop_beat = -1;

        // 6: start while busy ignored; extra beat after completion is an error
        clear_logs();
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_done(200);
        chk("t6_ncmd", cmd_log.size(), 16);
        chk("t6_rd_cnt", rd_cnt, 8);
        chk("t6_pass", pass, 1);
        inj_req++;
        repeat (3) @(negedge clk);
        chk("t6_extra_err", err_cnt, 1);
        chk("t6_extra_rd", rd_cnt, 9);
        chk("t6_extra_pass", pass, 0);
        chk("t6_done_held", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
